mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the CPU's single memory/IO port between two requesters:
  - the CPU load/store/fetch path (control unit plus datapath);
  - an external port (debug loader / DMA).
- Three-state FSM with round-robin arbitration and a fixed wait-state counter.
- Presents one registered memory-side interface.
- Sits between the CPU core and the memory/IO decode.

Parameters:
- ADDR_W, 16, address width
- DATA_W, 16, data width
- WAIT_STATES, 2, extra memory cycles per access (0..15); mem_en held WAIT_STATES+1 cycles

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- cpu_req_in  in  1  CPU request; held with its fields stable until cpu_ack_out
- cpu_we_in  in  1  1 = write, 0 = read
- cpu_addr_in  in  ADDR_W  CPU address
- cpu_wdata_in  in  DATA_W  CPU write data
- cpu_gnt_out  out  1  CPU owns the bus (ACCESS and RESP states)
- cpu_ack_out  out  1  one-cycle completion pulse
- cpu_rdata_out  out  DATA_W  read data, valid while cpu_ack_out is high
- ext_req_in, ext_we_in, ext_addr_in, ext_wdata_in  in  1/1/ADDR_W/DATA_W  external port, same rules as CPU
- ext_gnt_out, ext_ack_out, ext_rdata_out  out  1/1/DATA_W  external port, same rules as CPU
- mem_en_out  out  1  memory access strobe
- mem_we_out  out  1  memory write enable
- mem_addr_out  out  ADDR_W  memory address
- mem_wdata_out  out  DATA_W  memory write data
- mem_rdata_in  in  DATA_W  memory read data; valid in the last mem_en cycle
- owner_out  out  1  0 = CPU, 1 = EXT; last granted owner

Behaviour:
- Reset: every output 0; state IDLE; round-robin pointer set so the CPU wins the first tie; wait counter 0. Reset asserted mid-transaction aborts it: no ack is issued and all outputs are 0 after that edge.
- IDLE:
  - No request: stay in IDLE, all strobes 0.
  - One request: that requester wins.
  - Both requesting: the requester NOT equal to owner_out wins (round-robin).
- Grant edge (entering ACCESS): latch the winner's we/addr/wdata into the mem_* output registers, set mem_en_out=1, the winner's gnt=1, owner_out=winner, counter=WAIT_STATES.
- ACCESS:
  - mem_en_out and mem_*_out held stable.
  - Counter decrements each cycle.
  - When counter==0: capture mem_rdata_in into the winner's rdata register (reads only); next state RESP with mem_en_out=0 and mem_we_out=0.
- RESP: winner's ack=1 for exactly one cycle, gnt still 1. Next edge goes to IDLE: gnt=0, ack=0.
- Timing: request sampled at edge k → mem_en_out high in cycles k..k+WAIT_STATES → ack high in cycle k+WAIT_STATES+1. Bus occupancy is WAIT_STATES+3 cycles including the IDLE decision cycle.
- Back-to-back: a requester may keep req high after ack. It is re-arbitrated in the next IDLE cycle, so there is at least one idle cycle between transactions.
- Write transactions leave the rdata registers unchanged. The loser's rdata register never changes.
- req deasserted mid-transaction: ignored; the transaction completes and ack still pulses.
- Input fields are only sampled at the grant edge; later changes have no effect.
- WAIT_STATES=0: ACCESS lasts exactly one cycle.
- gnt_out signals are mutually exclusive; at most one ack is high per cycle.

Optional Feature:
- Macro: MEM_ARB_FIXED_PRI_EN
- Defined: simultaneous requests always go to the CPU, regardless of owner_out. owner_out still reports the last owner.
- Undefined: round-robin as described in Behaviour.
- No port changes either way.

Decomposition:
- Package mycpu_pkg adds:
  - arb_state_t enum {ARB_IDLE, ARB_ACCESS, ARB_RESP};
  - owner_t enum {OWNER_CPU=1'b0, OWNER_EXT=1'b1};
  - localparam MEM_WAIT_STATES=2 as the system default.
- Sub-module mem_wait_ctr: loadable 4-bit down-counter with load, dec and zero outputs. It is instantiated once.
- Winner selection, FSM and output registers stay in the top module.

Test Plan:
- CPU read alone, WAIT_STATES=2, addr 16'h0040, memory returns 16'hBEEF → mem_en_out high 3 cycles with addr 16'h0040, cpu_ack_out in 4th cycle after request, cpu_rdata_out=16'hBEEF, ext outputs stay 0.
- EXT write addr 16'h1234 data 16'hA5A5 → mem_we_out=1 and mem_wdata_out=16'hA5A5 for 3 cycles, one ext_ack_out pulse, ext_rdata_out unchanged.
- Both request continuously right after reset → grant order CPU, EXT, CPU, EXT. With MEM_ARB_FIXED_PRI_EN defined: CPU every time.
- CPU drops req and changes cpu_addr_in to 16'hFFFF during ACCESS → mem_addr_out keeps the latched address, ack still pulses once.
- rst_n low for one cycle during ACCESS → next cycle all outputs 0, no ack; then EXT-only request is granted normally.
- WAIT_STATES=0 build → mem_en_out single cycle, ack on the following cycle, 16'h7E57 read data correct.

Source files
------------

// File: rtl/mycpu_pkg.sv
// -----------------------------------------------------------------------------
// mycpu_pkg
//
// Purpose:
//   Shared types and defaults for the CPU memory-side blocks. The bus arbiter
//   and its wait-state counter import this package.
//
// Contents:
//   arb_state_t     - arbiter FSM states (idle / memory access / response)
//   owner_t         - identifies which requester owns the memory bus
//   MEM_WAIT_STATES - system default for extra memory cycles per access
//   WAIT_CTR_W      - width of the wait-state down-counter
// -----------------------------------------------------------------------------
package mycpu_pkg;

    // IDLE decides who gets the bus, ACCESS holds the memory strobe for the
    // programmed number of wait states, RESP pulses the winner's ack.
    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_t;

    // The encoding doubles as the owner_out pin value, so it is fixed here.
    typedef enum logic {
        OWNER_CPU = 1'b0,
        OWNER_EXT = 1'b1
    } owner_t;

    localparam int MEM_WAIT_STATES = 2;

    // Wait states are limited to 0..15, so four bits always suffice.
    localparam int WAIT_CTR_W = 4;

endpackage

// File: rtl/mem_wait_ctr.sv
// -----------------------------------------------------------------------------
// mem_wait_ctr
//
// Purpose:
//   Loadable down-counter that times the memory access phase of the bus
//   arbiter. The arbiter loads the wait-state count on the grant edge and
//   decrements once per access cycle; zero_out tells it the last memory
//   cycle is in progress.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   synchronous active-low reset (clears the count)
//   load_in     in   load load_val_in on the next edge (wins over dec_in)
//   dec_in      in   decrement on the next edge (ignored when already zero)
//   load_val_in in   value to load
//   zero_out    out  count is zero
// -----------------------------------------------------------------------------
module mem_wait_ctr
    import mycpu_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_in,
    input  logic                  dec_in,
    input  logic [WAIT_CTR_W-1:0] load_val_in,
    output logic                  zero_out
);

    logic [WAIT_CTR_W-1:0] count_q;
    logic [WAIT_CTR_W-1:0] count_d;

    // Load has priority so a new grant always restarts the timing, and the
    // decrement saturates at zero so a stray dec can never wrap to 15.
    always_comb begin
        count_d = count_q;
        if (load_in) begin
            count_d = load_val_in;
        end else if (dec_in && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Plain state register; reset is synchronous with the rest of the core.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_out = (count_q == '0);

endmodule

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Purpose:
//   Shares the CPU's single memory/IO port between the CPU load/store/fetch
//   path and an external port (debug loader / DMA). A three-state FSM picks a
//   winner in IDLE, holds a registered memory strobe for WAIT_STATES+1 cycles
//   in ACCESS, then pulses the winner's ack in RESP. Every output is a
//   register, so the memory decode sees clean, glitch-free signals.
//
// Configuration:
//   MEM_ARB_FIXED_PRI_EN - when defined, simultaneous requests always go to
//                          the CPU. When undefined (default), ties alternate
//                          round-robin, starting with the CPU after reset.
//
// Parameters:
//   ADDR_W      address width
//   DATA_W      data width
//   WAIT_STATES extra memory cycles per access (0..15)
//
// Ports:
//   clk, rst_n                 clock (rising edge), synchronous active-low reset
//   cpu_req_in/we/addr/wdata   CPU request and fields, held until cpu_ack_out
//   cpu_gnt_out                CPU owns the bus (ACCESS and RESP)
//   cpu_ack_out                one-cycle completion pulse
//   cpu_rdata_out              read data, valid while cpu_ack_out is high
//   ext_*                      external port, same rules as the CPU port
//   mem_en_out/we/addr/wdata   registered memory-side access
//   mem_rdata_in               memory read data, valid in the last mem_en cycle
//   owner_out                  last granted owner (0 = CPU, 1 = EXT)
// -----------------------------------------------------------------------------
module mem_bus_arbiter
    import mycpu_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int WAIT_STATES = MEM_WAIT_STATES
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              cpu_req_in,
    input  logic              cpu_we_in,
    input  logic [ADDR_W-1:0] cpu_addr_in,
    input  logic [DATA_W-1:0] cpu_wdata_in,
    output logic              cpu_gnt_out,
    output logic              cpu_ack_out,
    output logic [DATA_W-1:0] cpu_rdata_out,

    input  logic              ext_req_in,
    input  logic              ext_we_in,
    input  logic [ADDR_W-1:0] ext_addr_in,
    input  logic [DATA_W-1:0] ext_wdata_in,
    output logic              ext_gnt_out,
    output logic              ext_ack_out,
    output logic [DATA_W-1:0] ext_rdata_out,

    output logic              mem_en_out,
    output logic              mem_we_out,
    output logic [ADDR_W-1:0] mem_addr_out,
    output logic [DATA_W-1:0] mem_wdata_out,
    input  logic [DATA_W-1:0] mem_rdata_in,

    output logic              owner_out
);

    localparam logic [WAIT_CTR_W-1:0] WAIT_LOAD = WAIT_CTR_W'(WAIT_STATES);

    arb_state_t        state_q;
    owner_t            owner_q;
    logic              memEn_q;
    logic              memWe_q;
    logic [ADDR_W-1:0] memAddr_q;
    logic [DATA_W-1:0] memWdata_q;
    logic              cpuGnt_q;
    logic              extGnt_q;
    logic              cpuAck_q;
    logic              extAck_q;
    logic [DATA_W-1:0] cpuRdata_q;
    logic [DATA_W-1:0] extRdata_q;

    owner_t            winner_d;
    logic              selWe_d;
    logic [ADDR_W-1:0] selAddr_d;
    logic [DATA_W-1:0] selWdata_d;

    logic              anyReq;
    logic              ctrLoad;
    logic              ctrDec;
    logic              ctrZero;

    assign anyReq = cpu_req_in | ext_req_in;

`ifdef MEM_ARB_FIXED_PRI_EN

    // With fixed priority the CPU takes every tie, so the only case the
    // external port wins is when it requests alone.
    always_comb begin
        winner_d = OWNER_CPU;
        if (ext_req_in && !cpu_req_in) begin
            winner_d = OWNER_EXT;
        end
    end

`else

    // preferExt_q is the round-robin pointer. It is kept apart from owner_q
    // because owner_out must read 0 (CPU) after reset while the CPU must
    // still win the first tie; after any grant it equals "not the owner".
    logic preferExt_q;

    // Lone requesters always win; ties go to whoever the pointer favours.
    always_comb begin
        winner_d = OWNER_CPU;
        if (cpu_req_in && ext_req_in) begin
            winner_d = preferExt_q ? OWNER_EXT : OWNER_CPU;
        end else if (ext_req_in) begin
            winner_d = OWNER_EXT;
        end
    end

    // Flip the pointer on every grant so the loser of this round is favoured
    // next time both requesters collide.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            preferExt_q <= 1'b0;
        end else if (state_q == ARB_IDLE && anyReq) begin
            preferExt_q <= (winner_d == OWNER_CPU);
        end
    end

`endif

    // Route the winning requester's fields towards the memory registers; they
    // are only captured on the grant edge, so later input changes are ignored.
    always_comb begin
        selWe_d    = cpu_we_in;
        selAddr_d  = cpu_addr_in;
        selWdata_d = cpu_wdata_in;
        if (winner_d == OWNER_EXT) begin
            selWe_d    = ext_we_in;
            selAddr_d  = ext_addr_in;
            selWdata_d = ext_wdata_in;
        end
    end

    // The counter restarts on each grant and counts down through ACCESS; when
    // it reads zero the current cycle is the last one with mem_en high.
    assign ctrLoad = (state_q == ARB_IDLE) && anyReq;
    assign ctrDec  = (state_q == ARB_ACCESS) && !ctrZero;

    mem_wait_ctr u_wait_ctr (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_in    (ctrLoad),
        .dec_in     (ctrDec),
        .load_val_in(WAIT_LOAD),
        .zero_out   (ctrZero)
    );

    // Main FSM with all outputs registered. Reset clears everything, which
    // also aborts a transaction in flight without issuing its ack. Read data
    // is captured only for reads and only into the owner's register, so the
    // other requester's rdata never moves. mem_addr/mem_wdata keep their last
    // latched value once the access ends; only mem_en and mem_we drop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ARB_IDLE;
            owner_q    <= OWNER_CPU;
            memEn_q    <= 1'b0;
            memWe_q    <= 1'b0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
            cpuGnt_q   <= 1'b0;
            extGnt_q   <= 1'b0;
            cpuAck_q   <= 1'b0;
            extAck_q   <= 1'b0;
            cpuRdata_q <= '0;
            extRdata_q <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (anyReq) begin
                        state_q    <= ARB_ACCESS;
                        owner_q    <= winner_d;
                        memEn_q    <= 1'b1;
                        memWe_q    <= selWe_d;
                        memAddr_q  <= selAddr_d;
                        memWdata_q <= selWdata_d;
                        cpuGnt_q   <= (winner_d == OWNER_CPU);
                        extGnt_q   <= (winner_d == OWNER_EXT);
                    end
                end

                ARB_ACCESS: begin
                    if (ctrZero) begin
                        state_q  <= ARB_RESP;
                        memEn_q  <= 1'b0;
                        memWe_q  <= 1'b0;
                        cpuAck_q <= cpuGnt_q;
                        extAck_q <= extGnt_q;
                        if (!memWe_q) begin
                            if (owner_q == OWNER_EXT) begin
                                extRdata_q <= mem_rdata_in;
                            end else begin
                                cpuRdata_q <= mem_rdata_in;
                            end
                        end
                    end
                end

                ARB_RESP: begin
                    state_q  <= ARB_IDLE;
                    cpuGnt_q <= 1'b0;
                    extGnt_q <= 1'b0;
                    cpuAck_q <= 1'b0;
                    extAck_q <= 1'b0;
                end

                default: begin
                    state_q  <= ARB_IDLE;
                    memEn_q  <= 1'b0;
                    memWe_q  <= 1'b0;
                    cpuGnt_q <= 1'b0;
                    extGnt_q <= 1'b0;
                    cpuAck_q <= 1'b0;
                    extAck_q <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_gnt_out   = cpuGnt_q;
    assign cpu_ack_out   = cpuAck_q;
    assign cpu_rdata_out = cpuRdata_q;
    assign ext_gnt_out   = extGnt_q;
    assign ext_ack_out   = extAck_q;
    assign ext_rdata_out = extRdata_q;
    assign mem_en_out    = memEn_q;
    assign mem_we_out    = memWe_q;
    assign mem_addr_out  = memAddr_q;
    assign mem_wdata_out = memWdata_q;
    assign owner_out     = owner_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
//
// Purpose:
//   Self-checking bench for mem_bus_arbiter. A short directed sequence is
//   followed by randomized traffic; every cycle all outputs are compared
//   against a transaction-timeline reference model.
//
// Configuration:
//   MEM_ARB_FIXED_PRI_EN - when defined, the model gives every tie to the CPU.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;
    import mycpu_pkg::*;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int WS = MEM_WAIT_STATES;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cpu_req_in, cpu_we_in, ext_req_in, ext_we_in;
    logic [AW-1:0] cpu_addr_in, ext_addr_in;
    logic [DW-1:0] cpu_wdata_in, ext_wdata_in, mem_rdata_in;
    logic          cpu_gnt_out, cpu_ack_out, ext_gnt_out, ext_ack_out;
    logic [DW-1:0] cpu_rdata_out, ext_rdata_out;
    logic          mem_en_out, mem_we_out, owner_out;
    logic [AW-1:0] mem_addr_out;
    logic [DW-1:0] mem_wdata_out;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .WAIT_STATES(WS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cpu_req_in   (cpu_req_in),
        .cpu_we_in    (cpu_we_in),
        .cpu_addr_in  (cpu_addr_in),
        .cpu_wdata_in (cpu_wdata_in),
        .cpu_gnt_out  (cpu_gnt_out),
        .cpu_ack_out  (cpu_ack_out),
        .cpu_rdata_out(cpu_rdata_out),
        .ext_req_in   (ext_req_in),
        .ext_we_in    (ext_we_in),
        .ext_addr_in  (ext_addr_in),
        .ext_wdata_in (ext_wdata_in),
        .ext_gnt_out  (ext_gnt_out),
        .ext_ack_out  (ext_ack_out),
        .ext_rdata_out(ext_rdata_out),
        .mem_en_out   (mem_en_out),
        .mem_we_out   (mem_we_out),
        .mem_addr_out (mem_addr_out),
        .mem_wdata_out(mem_wdata_out),
        .mem_rdata_in (mem_rdata_in),
        .owner_out    (owner_out)
    );

    int checkCount = 0;
    int passCount  = 0;
    int cycleNum   = 0;

    // Reference model: one transaction at a time, described by its start edge.
    // Relative to the grant edge s, mem_en is high for cycles s..s+WS, ack is
    // high in cycle s+WS+1, and the next grant can happen at edge s+WS+3.
    bit            mActive    = 1'b0;
    int            mStart     = 0;
    bit            mExt       = 1'b0;
    bit            mWe        = 1'b0;
    bit            mOwner     = 1'b0;
    bit            mPreferExt = 1'b0;
    logic [AW-1:0] mAddr      = '0;
    logic [DW-1:0] mWdata     = '0;
    logic [DW-1:0] mCpuRd     = '0;
    logic [DW-1:0] mExtRd     = '0;

    // Single comparison point; every mismatch prints one FAIL line.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed %h expected %h (cycle %0d)",
                     tag, observed, expected, cycleNum);
        end
    endtask

    // Advance the model by one rising edge using the inputs present at it.
    task automatic modelEdge();
        cycleNum++;
        if (!rst_n) begin
            mActive    = 1'b0;
            mExt       = 1'b0;
            mWe        = 1'b0;
            mOwner     = 1'b0;
            mPreferExt = 1'b0;
            mAddr      = '0;
            mWdata     = '0;
            mCpuRd     = '0;
            mExtRd     = '0;
            return;
        end
        if (mActive && (cycleNum - mStart == WS + 1) && !mWe) begin
            if (mExt) mExtRd = mem_rdata_in;
            else      mCpuRd = mem_rdata_in;
        end
        if (mActive && (cycleNum - mStart >= WS + 3)) mActive = 1'b0;
        if (!mActive && (cpu_req_in || ext_req_in)) begin
            if (cpu_req_in && ext_req_in) begin
`ifdef MEM_ARB_FIXED_PRI_EN
                mExt = 1'b0;
`else
                mExt = mPreferExt;
`endif
            end else begin
                mExt = ext_req_in;
            end
            mWe        = mExt ? ext_we_in    : cpu_we_in;
            mAddr      = mExt ? ext_addr_in  : cpu_addr_in;
            mWdata     = mExt ? ext_wdata_in : cpu_wdata_in;
            mActive    = 1'b1;
            mStart     = cycleNum;
            mOwner     = mExt;
            mPreferExt = !mExt;
        end
    endtask

    // Compare every output against what the model says this cycle looks like.
    task automatic checkAll();
        int p;
        bit acc;
        bit resp;
        p    = cycleNum - mStart;
        acc  = mActive && (p <= WS);
        resp = mActive && (p == WS + 1);
        checkOutput("mem_en",    32'(mem_en_out),    32'(acc));
        checkOutput("mem_we",    32'(mem_we_out),    32'(acc && mWe));
        checkOutput("mem_addr",  32'(mem_addr_out),  32'(mAddr));
        checkOutput("mem_wdata", 32'(mem_wdata_out), 32'(mWdata));
        checkOutput("cpu_gnt",   32'(cpu_gnt_out),   32'((acc || resp) && !mExt));
        checkOutput("ext_gnt",   32'(ext_gnt_out),   32'((acc || resp) && mExt));
        checkOutput("cpu_ack",   32'(cpu_ack_out),   32'(resp && !mExt));
        checkOutput("ext_ack",   32'(ext_ack_out),   32'(resp && mExt));
        checkOutput("owner",     32'(owner_out),     32'(mOwner));
        checkOutput("cpu_rdata", 32'(cpu_rdata_out), 32'(mCpuRd));
        checkOutput("ext_rdata", 32'(ext_rdata_out), 32'(mExtRd));
    endtask

    // Drive one cycle of inputs on the falling edge, step the model on the
    // rising edge, then check outputs shortly after it.
    task automatic applyStimulus(input logic rn,
                                 input logic cr, input logic cw,
                                 input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                                 input logic er, input logic ew,
                                 input logic [AW-1:0] ea, input logic [DW-1:0] ed,
                                 input logic [DW-1:0] md);
        @(negedge clk);
        rst_n        = rn;
        cpu_req_in   = cr;
        cpu_we_in    = cw;
        cpu_addr_in  = ca;
        cpu_wdata_in = cd;
        ext_req_in   = er;
        ext_we_in    = ew;
        ext_addr_in  = ea;
        ext_wdata_in = ed;
        mem_rdata_in = md;
        @(posedge clk);
        modelEdge();
        #1;
        checkAll();
    endtask

    initial begin
        rst_n        = 1'b0;
        cpu_req_in   = 1'b0;
        cpu_we_in    = 1'b0;
        cpu_addr_in  = '0;
        cpu_wdata_in = '0;
        ext_req_in   = 1'b0;
        ext_we_in    = 1'b0;
        ext_addr_in  = '0;
        ext_wdata_in = '0;
        mem_rdata_in = '0;

        // Reset for a few cycles.
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, '0);

        // CPU read of 0x0040, memory returns 0xBEEF.
        for (int i = 0; i < 7; i++)
            applyStimulus(1'b1, i < 4, 1'b0, 16'h0040, 16'h0000,
                          1'b0, 1'b0, 16'h0000, 16'h0000, 16'hBEEF);

        // EXT write 0xA5A5 to 0x1234 while memory drives unrelated data.
        for (int i = 0; i < 7; i++)
            applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000,
                          i < 4, 1'b1, 16'h1234, 16'hA5A5, 16'h5555);

        // Reset, then both request continuously: ties alternate from the CPU.
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, '0);
        for (int i = 0; i < 24; i++)
            applyStimulus(1'b1, 1'b1, 1'b0, 16'h0100, 16'h0000,
                          1'b1, 1'b0, 16'h0200, 16'h0000, 16'(16'h3000 + i));

        // CPU read, then req dropped and address changed during ACCESS.
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, '0);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0300, 16'h0000,
                      1'b0, 1'b0, 16'h0000, 16'h0000, 16'h1111);
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h0000,
                          1'b0, 1'b0, 16'h0000, 16'h0000, 16'h2222);

        // EXT read aborted by a one-cycle reset during ACCESS, then redone.
        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 16'h0444, '0, 16'h7E57);
        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 16'h0444, '0, 16'h7E57);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 16'h0444, '0, 16'h7E57);
        for (int i = 0; i < 7; i++)
            applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, i < 4, 1'b0, 16'h0555, '0, 16'h7E57);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 800; i++)
            applyStimulus($urandom_range(0, 99) != 0,
                          $urandom_range(0, 3) != 0, 1'($urandom),
                          16'($urandom), 16'($urandom),
                          $urandom_range(0, 3) != 0, 1'($urandom),
                          16'($urandom), 16'($urandom),
                          16'($urandom));

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
